// File: rtl/life_engine.sv
// Game-of-Life core: stores a ROWS x COLS grid, advances on a timer or step pulse, scans rows onto LEDs.
// Latency: a generation lands in cells 1 clk after its advance request; row_sel/leds_out decode with no added latency.
// Backpressure: none, every request is taken on the clock it arrives. Define LIFE_TORUS_EN for wrap-around edges.
module life_engine #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int GEN_TICKS  = 12_000_000,
  parameter int SCAN_TICKS = 1_000,
  parameter logic [ROWS*COLS-1:0] INIT = 64'h1C00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 step,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] load_data,
  output logic [ROWS*COLS-1:0] cells,
  output logic [ROWS-1:0]      row_sel,
  output logic [COLS-1:0]      leds_out,
  output logic                 gen_pulse,
  output logic [15:0]          gen_count,
  output logic                 extinct
);

  localparam int PR = ROWS + 2;
  localparam int PC = COLS + 2;
  localparam int GW = $clog2(GEN_TICKS);
  localparam int SW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int RW = $clog2(ROWS);

  logic [GW-1:0]        gen_timer;
  logic [SW-1:0]        scan_timer;
  logic [RW-1:0]        scan_row;
  logic [PR*PC-1:0]     pad;
  logic [ROWS*COLS-1:0] next_cells;
  logic                 timer_wrap;
  logic                 adv_req;

  // Grid framed by a one-cell border so every cell sees 8 in-range neighbours.
  for (genvar pr = 0; pr < PR; pr++) begin : g_pad_r
    for (genvar pc = 0; pc < PC; pc++) begin : g_pad_c
`ifdef LIFE_TORUS_EN
      localparam int SR = (pr + ROWS - 1) % ROWS;
      localparam int SC = (pc + COLS - 1) % COLS;
      assign pad[pr*PC + pc] = cells[SR*COLS + SC];
`else
      if (pr == 0 || pr == PR - 1 || pc == 0 || pc == PC - 1) begin : g_edge
        assign pad[pr*PC + pc] = 1'b0;
      end else begin : g_in
        assign pad[pr*PC + pc] = cells[(pr-1)*COLS + (pc-1)];
      end
`endif
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [3:0] n;
      assign n = 4'(pad[ r   *PC + c]) + 4'(pad[ r   *PC + c+1]) + 4'(pad[ r   *PC + c+2])
               + 4'(pad[(r+1)*PC + c])                            + 4'(pad[(r+1)*PC + c+2])
               + 4'(pad[(r+2)*PC + c]) + 4'(pad[(r+2)*PC + c+1]) + 4'(pad[(r+2)*PC + c+2]);
      assign next_cells[r*COLS + c] = (n == 4'd3) || (cells[r*COLS + c] && n == 4'd2);
    end
  end

  assign timer_wrap = ena && (gen_timer == GW'(GEN_TICKS - 1));
  assign adv_req    = timer_wrap || (step && !ena);

  always_ff @(posedge clk) begin
    if (rst) begin
      cells      <= INIT;
      gen_count  <= 16'd0;
      gen_pulse  <= 1'b0;
      gen_timer  <= '0;
      scan_timer <= '0;
      scan_row   <= '0;
    end else begin
      if (scan_timer == SW'(SCAN_TICKS - 1)) begin
        scan_timer <= '0;
        scan_row   <= (scan_row == RW'(ROWS - 1)) ? '0 : scan_row + RW'(1);
      end else begin
        scan_timer <= scan_timer + SW'(1);
      end

      gen_pulse <= 1'b0;
      if (load) begin
        // A load discards any advance requested in the same cycle.
        cells     <= load_data;
        gen_count <= 16'd0;
        gen_timer <= '0;
      end else begin
        if (ena) gen_timer <= timer_wrap ? '0 : gen_timer + GW'(1);
        if (adv_req) begin
          cells     <= next_cells;
          gen_count <= gen_count + 16'd1;
          gen_pulse <= 1'b1;
        end
      end
    end
  end

  assign row_sel  = {{(ROWS-1){1'b0}}, 1'b1} << scan_row;
  assign leds_out = cells[scan_row*COLS +: COLS];
  assign extinct  = (cells == '0);

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine with short timer periods (GEN_TICKS=4, SCAN_TICKS=3).
module tb_life_engine;

  logic        clk = 1'b0;
  logic        rst, ena, step, load;
  logic [63:0] load_data;
  logic [63:0] cells;
  logic [7:0]  row_sel, leds_out;
  logic        gen_pulse, extinct;
  logic [15:0] gen_count;

  int checks = 0;
  int errors = 0;
  int pulse_cnt;

  life_engine #(
    .ROWS(8), .COLS(8), .GEN_TICKS(4), .SCAN_TICKS(3), .INIT(64'h1C00)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .step(step), .load(load), .load_data(load_data),
    .cells(cells), .row_sel(row_sel), .leds_out(leds_out), .gen_pulse(gen_pulse),
    .gen_count(gen_count), .extinct(extinct)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; step = 1'b0; load = 1'b0; load_data = '0;
    tick();
    tick();

    // Reset state
    rst = 1'b0;
    check("rst_cells", cells, 64'h1C00);
    check("rst_gen_count", gen_count, 0);
    check("rst_gen_pulse", gen_pulse, 0);
    check("rst_row_sel", row_sel, 8'h01);
    check("rst_leds", leds_out, 8'h00);
    check("rst_extinct", extinct, 0);

    // 1: timer-driven generations
    ena = 1'b1;
    pulse_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulse_cnt += gen_pulse;
    end
    check("t1_before_gen", cells, 64'h1C00);
    tick();
    pulse_cnt += gen_pulse;
    check("t1_gen1_cells", cells, 64'h0000_0000_0008_0808);
    check("t1_gen1_pulse", gen_pulse, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      pulse_cnt += gen_pulse;
    end
    ena = 1'b0;
    check("t1_gen2_cells", cells, 64'h1C00);
    check("t1_gen2_count", gen_count, 2);
    check("t1_pulse_total", pulse_cnt, 2);

    // 2: step while paused
    do_reset();
    ena = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    check("t2_step1_cells", cells, 64'h0000_0000_0008_0808);
    check("t2_step1_pulse", gen_pulse, 1);
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("t2_count", gen_count, 2);
    check("t2_cells", cells, 64'h1C00);
    ena = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    ena = 1'b0;
    tick();
    check("t2_step_ena_ignored", gen_count, 2);

    // 3: load then one step
    load = 1'b1;
    load_data = 64'h7;
    tick();
    load = 1'b0;
    check("t3_loaded", cells, 64'h7);
    check("t3_load_count", gen_count, 0);
    step = 1'b1;
    tick();
    step = 1'b0;
`ifdef LIFE_TORUS_EN
    check("t3_step_cells", cells, 64'h0200_0000_0000_0202);
`else
    check("t3_step_cells", cells, 64'h0202);
`endif
    check("t3_step_count", gen_count, 1);

    // 4: load beats step; empty grid
    load = 1'b1;
    step = 1'b1;
    load_data = 64'h1C00;
    tick();
    load = 1'b0;
    step = 1'b0;
    check("t4_load_wins_cells", cells, 64'h1C00);
    check("t4_load_wins_count", gen_count, 0);
    check("t4_load_no_pulse", gen_pulse, 0);
    load = 1'b1;
    load_data = 64'h0;
    tick();
    load = 1'b0;
    check("t4_empty_extinct", extinct, 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("t4_empty_cells", cells, 0);
    check("t4_empty_extinct2", extinct, 1);
    check("t4_empty_count", gen_count, 1);

    // 5: row scan
    do_reset();
    for (int k = 0; k < 25; k++) begin
      int r;
      r = (k / 3) % 8;
      check($sformatf("t5_row_sel_%0d", k), row_sel, 64'(8'h01 << r));
      check($sformatf("t5_leds_%0d", k), leds_out, (r == 1) ? 64'h1C : 64'h0);
      tick();
    end

    // 6: reset mid-generation
    do_reset();
    ena = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("t6_pre_count", gen_count, 1);
    check("t6_pre_cells", cells, 64'h0000_0000_0008_0808);
    rst = 1'b1;
    tick();
    check("t6_rst_cells", cells, 64'h1C00);
    check("t6_rst_count", gen_count, 0);
    check("t6_rst_pulse", gen_pulse, 0);
    check("t6_rst_row_sel", row_sel, 8'h01);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("t6_no_early_gen", gen_count, 0);
    tick();
    check("t6_first_gen_count", gen_count, 1);
    check("t6_first_gen_pulse", gen_pulse, 1);
    ena = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
